// File: rtl/fifo_sync.sv
// Single-clock circular-buffer FIFO with occupancy count and almost-empty/almost-full flags.
module fifo_sync #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 4,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned AF_THRESH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic [CNT_WIDTH-1:0]  fifo_counter,
  output logic                  almostEmpty,
  output logic                  almostFull
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  wr_ok;
  logic                  rd_ok;

  // Accept decisions and next occupancy; a full FIFO lets the read win, an empty one the write
  always_comb begin
    wr_ok       = wr_en && (fifo_counter < CNT_WIDTH'(DEPTH));
    rd_ok       = rd_en && (fifo_counter != '0);
    count_next  = fifo_counter;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_ok && !rd_ok) begin
      count_next = fifo_counter + CNT_WIDTH'(1);
    end else if (rd_ok && !wr_ok) begin
      count_next = fifo_counter - CNT_WIDTH'(1);
    end
    if (wr_ok) begin
      wr_ptr_next = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_next = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // Storage array; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= DataIn;
    end
  end

  // Pointers, count, read data and flags; flags are registered from the next count so they track fifo_counter exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      DataOut      <= '0;
      almostEmpty  <= 1'b1;
      almostFull   <= (AF_THRESH == 0);
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      fifo_counter <= count_next;
      almostEmpty  <= (count_next <= CNT_WIDTH'(AE_THRESH));
      almostFull   <= (count_next >= CNT_WIDTH'(AF_THRESH));
      if (rd_ok) begin
        DataOut <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed scoreboard bench for fifo_sync: stimulus queues expectations, a monitor checks them after each edge.
module tb_fifo_sync;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] DataIn;
  logic [3:0] DataOut;
  logic [3:0] fifo_counter;
  logic       almostEmpty;
  logic       almostFull;

  typedef struct {
    int         id;
    logic [3:0] cnt;
    logic [3:0] dout;
    logic       ae;
    logic       af;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  fifo_sync dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .DataIn       (DataIn),
    .DataOut      (DataOut),
    .fifo_counter (fifo_counter),
    .almostEmpty  (almostEmpty),
    .almostFull   (almostFull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, required %0d", name, id, act, req);
    end
  endtask

  // One directed cycle: drive at negedge and queue what must be visible after the next rising edge
  task automatic step(input logic w, input logic r, input logic [3:0] d,
                      input int cnt, input int dout);
    exp_t e;
    @(negedge clk);
    wr_en  = w;
    rd_en  = r;
    DataIn = d;
    step_id++;
    e.id   = step_id;
    e.cnt  = 4'(cnt);
    e.dout = 4'(dout);
    e.ae   = (cnt <= 2);
    e.af   = (cnt >= 6);
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_cnt"}, step_id, int'(fifo_counter), 0);
    chk({name, "_dout"}, step_id, int'(DataOut), 0);
    chk({name, "_ae"}, step_id, int'(almostEmpty), 1);
    chk({name, "_af"}, step_id, int'(almostFull), 0);
  endtask

  // Monitor: after every rising edge, compare outputs against the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", e.id, int'(fifo_counter), int'(e.cnt));
      chk("dataout", e.id, int'(DataOut), int'(e.dout));
      chk("almost_empty", e.id, int'(almostEmpty), int'(e.ae));
      chk("almost_full", e.id, int'(almostFull), int'(e.af));
    end
  end

  initial begin
    int last;
    int word;
    int waited;
    rst    = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    DataIn = '0;

    // Reset held with random requests
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en  = 1'($urandom_range(0, 1));
      rd_en  = 1'($urandom_range(0, 1));
      DataIn = 4'($urandom_range(0, 15));
      #1 chk_reset_state("reset_hold");
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Fill 1..8, then a write while full is ignored
    for (int i = 1; i <= 8; i++) step(1, 0, 4'(i), i, 0);
    step(1, 0, 4'd9, 8, 0);

    // Drain 1..8, then a read while empty holds DataOut
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 8 - i, i);
    step(0, 1, 0, 0, 8);

    // Simultaneous read/write at count 4
    for (int i = 0; i < 4; i++) step(1, 0, 4'(10 + i), i + 1, 8);
    step(1, 1, 4'd14, 4, 10);
    step(1, 1, 4'd15, 4, 11);
    step(1, 1, 4'd0, 4, 12);
    step(1, 1, 4'd1, 4, 13);
    step(1, 1, 4'd2, 4, 14);
    step(0, 1, 0, 3, 15);
    step(0, 1, 0, 2, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 0, 2);

    // Simultaneous on empty: write only, no bypass
    step(1, 1, 4'd5, 1, 2);
    // Fill to full with 6..12, then simultaneous on full: read only
    for (int i = 0; i < 7; i++) step(1, 0, 4'(6 + i), 2 + i, 2);
    step(1, 1, 4'd13, 7, 5);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 6 - i, 6 + i);

    // Wrap-around: 4 rounds of 5 writes then 5 reads, values 0..15 repeating
    last = 12;
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int j = 0; j < 5; j++) begin
        word = (rnd * 5 + j) % 16;
        step(1, 0, 4'(word), j + 1, last);
      end
      for (int j = 0; j < 5; j++) begin
        word = (rnd * 5 + j) % 16;
        step(0, 1, 0, 4 - j, word);
        last = word;
      end
    end

    // Asynchronous reset mid-stream at count 5
    for (int i = 0; i < 5; i++) step(1, 0, 4'(9 + i), i + 1, 3);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_state("async_reset");
    #1 rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 4'd6, 1, 0);
    step(0, 1, 0, 0, 6);

    // Let the monitor drain the scoreboard, bounded
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
